// File: rtl/seq_detect_mealy.sv
// Mealy serial-pattern detector: runtime-loadable pattern, overlap/non-overlap
// selection, same-cycle match output plus a registered copy and a saturating counter.
module seq_detect_mealy #(
  parameter int          PAT_WIDTH   = 4,
  parameter int          COUNT_WIDTH = 8,
  parameter logic [15:0] RESET_PAT   = 16'b0000_0000_0000_1011
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   x,
  input  logic                   load,
  input  logic [PAT_WIDTH-1:0]   pattern_in,
  input  logic                   overlap,
  input  logic                   clr_count,
  output logic                   y,
  output logic                   y_q,
  output logic [COUNT_WIDTH-1:0] match_count,
  output logic                   count_sat
);

  localparam int                     FILL_W     = $clog2(PAT_WIDTH);
  localparam logic [FILL_W-1:0]      FILL_MAX   = FILL_W'(PAT_WIDTH - 1);
  localparam logic [FILL_W-1:0]      FILL_ONE   = FILL_W'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_MAX - COUNT_ONE;
  localparam logic [PAT_WIDTH-1:0]   PAT_RST    = RESET_PAT[PAT_WIDTH-1:0];

  logic [PAT_WIDTH-1:0]   pat_r;
  logic [PAT_WIDTH-2:0]   hist_r;
  logic [FILL_W-1:0]      fill_r;
  logic [COUNT_WIDTH-1:0] count_r;
  logic                   sat_r;
  logic                   y_q_r;
  logic [PAT_WIDTH-1:0]   window_s;
  logic                   match_s;

  // The completing bit on x joins the stored history to form the candidate window.
  assign window_s = {hist_r, x};
  assign match_s  = en & ~load & (fill_r == FILL_MAX) & (window_s == pat_r);

  assign y           = match_s;
  assign y_q         = y_q_r;
  assign match_count = count_r;
  assign count_sat   = sat_r;

  // Pattern register, bit history and fill level; load wins over an accepted bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_r  <= PAT_RST;
      hist_r <= '0;
      fill_r <= '0;
    end else if (load) begin
      pat_r  <= pattern_in;
      hist_r <= '0;
      fill_r <= '0;
    end else if (en) begin
      if (match_s && !overlap) begin
        hist_r <= '0;
        fill_r <= '0;
      end else begin
        hist_r <= window_s[PAT_WIDTH-2:0];
        if (fill_r != FILL_MAX) begin
          fill_r <= fill_r + FILL_ONE;
        end else begin
          fill_r <= fill_r;
        end
      end
    end else begin
      hist_r <= hist_r;
      fill_r <= fill_r;
    end
  end

  // Registered match copy and saturating counter; clear beats a simultaneous match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q_r   <= 1'b0;
      count_r <= '0;
      sat_r   <= 1'b0;
    end else begin
      y_q_r <= match_s;
      if (clr_count) begin
        count_r <= '0;
        sat_r   <= 1'b0;
      end else if (match_s && (count_r != COUNT_MAX)) begin
        count_r <= count_r + COUNT_ONE;
        if (count_r == COUNT_LAST) begin
          sat_r <= 1'b1;
        end else begin
          sat_r <= sat_r;
        end
      end else begin
        count_r <= count_r;
        sat_r   <= sat_r;
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_mealy.sv
// Bench for seq_detect_mealy: a 4-bit/8-bit instance and a 2-bit/2-bit instance
// share stimulus and are checked against a queue-based model of accepted bits.
module tb_seq_detect_mealy;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, x = 1'b0, load = 1'b0, overlap = 1'b1, clr_count = 1'b0;
  logic [3:0] pattern_in = 4'b0000;
  logic       y1, yq1, sat1, y2, yq2, sat2;
  logic [7:0] cnt1;
  logic [1:0] cnt2;

  int checks = 0;
  int failures = 0;

  // model state: bits accepted since the last reset/load/non-overlap consumption
  bit         q1[$];
  bit         q2[$];
  logic [3:0] pat1;
  logic [1:0] pat2;
  int         mcnt1, mcnt2;
  bit         eyq1, eyq2;

  always #5 clk = ~clk;

  seq_detect_mealy #(.PAT_WIDTH(4), .COUNT_WIDTH(8), .RESET_PAT(16'h000B)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pattern_in(pattern_in),
    .overlap(overlap), .clr_count(clr_count), .y(y1), .y_q(yq1),
    .match_count(cnt1), .count_sat(sat1));

  seq_detect_mealy #(.PAT_WIDTH(2), .COUNT_WIDTH(2), .RESET_PAT(16'h0003)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pattern_in(pattern_in[1:0]),
    .overlap(overlap), .clr_count(clr_count), .y(y2), .y_q(yq2),
    .match_count(cnt2), .count_sat(sat2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // last w bits of the accepted stream (oldest = MSB) followed by xb must equal pat
  function automatic bit mdl_match(input bit q[$], input int w, input logic [15:0] pat,
                                   input bit xb);
    if (q.size() < w - 1) return 1'b0;
    for (int i = 0; i < w - 1; i++)
      if (q[q.size() - w + 1 + i] != pat[w-1-i]) return 1'b0;
    return xb == pat[0];
  endfunction

  task automatic mdl_reset();
    q1.delete(); q2.delete();
    pat1 = 4'b1011; pat2 = 2'b11;
    mcnt1 = 0; mcnt2 = 0; eyq1 = 1'b0; eyq2 = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_yq1"}, yq1, eyq1);
    chk({tag, "_cnt1"}, cnt1, mcnt1);
    chk({tag, "_sat1"}, sat1, mcnt1 == 255);
    chk({tag, "_yq2"}, yq2, eyq2);
    chk({tag, "_cnt2"}, cnt2, mcnt2);
    chk({tag, "_sat2"}, sat2, mcnt2 == 3);
  endtask

  // one clock: drive at negedge, check y mid-low-phase, check registers after posedge
  task automatic step(input bit e, input bit xb, input bit ld, input logic [3:0] p,
                      input bit ov, input bit clr);
    bit e1, e2;
    en = e; x = xb; load = ld; pattern_in = p; overlap = ov; clr_count = clr;
    #1;
    e1 = e && !ld && mdl_match(q1, 4, {12'd0, pat1}, xb);
    e2 = e && !ld && mdl_match(q2, 2, {14'd0, pat2}, xb);
    chk("y1", y1, e1);
    chk("y2", y2, e2);
    @(posedge clk);
    if (ld) begin
      q1.delete(); q2.delete(); pat1 = p; pat2 = p[1:0];
    end else if (e) begin
      if (e1 && !ov) q1.delete(); else q1.push_back(xb);
      if (e2 && !ov) q2.delete(); else q2.push_back(xb);
      if (q1.size() > 16) void'(q1.pop_front());
      if (q2.size() > 16) void'(q2.pop_front());
    end
    if (clr) begin
      mcnt1 = 0; mcnt2 = 0;
    end else begin
      if (e1 && mcnt1 < 255) mcnt1++;
      if (e2 && mcnt2 < 3) mcnt2++;
    end
    eyq1 = e1; eyq2 = e2;
    #1;
    check_regs("step");
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    mdl_reset();
    chk("rst_y1", y1, 1'b0);
    chk("rst_y2", y2, 1'b0);
    check_regs("rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic stream(input logic [6:0] bits, input int n, input bit ov);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0, 4'b0000, ov, 1'b0);
  endtask

  initial begin
    mdl_reset();
    @(negedge clk);
    do_reset();

    // overlapping 1011 on 1011011: matches at indices 3 and 6
    stream(7'b1011011, 7, 1'b1);
    chk("t1_count", cnt1, 8'd2);

    // non-overlapping: only index 3
    do_reset();
    stream(7'b1011011, 7, 1'b0);
    chk("t2_count", cnt1, 8'd1);

    // history ends 1,0,1 so x=1 would complete 1011, but the load cycle forces y=0
    stream(7'b0000101, 3, 1'b0);
    step(1'b1, 1'b1, 1'b1, 4'b0110, 1'b1, 1'b1);
    chk("t3_loadcnt", cnt1, 8'd0);
    stream(7'b0110110, 7, 1'b1);
    chk("t3_count", cnt1, 8'd2);

    // en gaps do not break a partial match
    step(1'b1, 1'b0, 1'b1, 4'b1011, 1'b1, 1'b1);
    stream(7'b0000010, 2, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, i[0], 1'b0, 4'b0000, 1'b1, 1'b0);
    stream(7'b0000011, 2, 1'b1);
    chk("t4_count", cnt1, 8'd1);

    // 2-bit instance saturation on pattern 11, then clear beats a match
    do_reset();
    stream(7'b0111111, 6, 1'b1);
    chk("sat_count", cnt2, 2'd3);
    chk("sat_flag", sat2, 1'b1);
    step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1);
    chk("clr_count", cnt2, 2'd0);
    chk("clr_flag", sat2, 1'b0);

    // asynchronous reset in the middle of a would-be match
    step(1'b1, 1'b1, 1'b1, 4'b0110, 1'b1, 1'b1);
    do_reset();
    stream(7'b0000101, 3, 1'b1);
    en = 1'b1; x = 1'b1; load = 1'b0; clr_count = 1'b0;
    #1;
    chk("pre_rst_y1", y1, 1'b1);
    rst = 1'b1;
    #1;
    mdl_reset();
    chk("mid_rst_y1", y1, 1'b0);
    check_regs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    stream(7'b0000001, 1, 1'b1);
    stream(7'b0001011, 4, 1'b1);
    chk("t6_count", cnt1, 8'd1);

    // randomized traffic against the model
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 24) == 0,
           4'($urandom), 1'($urandom), $urandom_range(0, 40) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
